// File: rtl/key_sched_arbiter.sv
// Round-robin front end that shares one key_expansion instance among NUM_REQ
// cipher cores, with a one-entry tag so a repeated key skips re-expansion.
module key_sched_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [127:0]       req_key_i [NUM_REQ],
  output logic [NUM_REQ-1:0] req_done_o,
  input  logic               flush_i,
  output logic               ke_valid_o,
  input  logic               ke_ready_i,
  output logic [127:0]       ke_key_o,
  input  logic               ke_done_i,
  output logic               keys_valid_o,
  output logic [IDW-1:0]     keys_owner_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int unsigned    SW    = IDW + 1;
  localparam logic [SW-1:0]  NUM_W = SW'(NUM_REQ);

  state_t         state, state_d;
  logic [IDW-1:0] grant_idx, grant_d;
  logic [IDW-1:0] owner, owner_d;
  logic [IDW-1:0] rr_ptr, rr_d;
  logic [127:0]   key_lat, key_lat_d;
  logic [127:0]   tag, tag_d;
  logic           tag_valid, tag_valid_d;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [SW-1:0]  rr_sum;
  logic [IDW-1:0] cand_idx;

  // Walk requesters from rr_ptr upward; the extra sum bit keeps the wrap exact
  // when NUM_REQ is not a power of two.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_sum     = '0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rr_sum   = {1'b0, rr_ptr} + SW'(i);
      cand_idx = (rr_sum >= NUM_W) ? IDW'(rr_sum - NUM_W) : IDW'(rr_sum);
      if (!pick_found && req_valid_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d     = state;
    grant_d     = grant_idx;
    key_lat_d   = key_lat;
    tag_d       = tag;
    tag_valid_d = tag_valid;
    owner_d     = owner;
    rr_d        = rr_ptr;

    unique case (state)
      S_IDLE: begin
        if (pick_found) begin
          grant_d   = pick_idx;
          key_lat_d = req_key_i[pick_idx];
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (tag_valid && (key_lat == tag)) begin
          owner_d = grant_idx;
          state_d = S_RESP;
        end else begin
          // Bank contents are about to be overwritten by the expander.
          tag_valid_d = 1'b0;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (ke_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ke_done_i) begin
          tag_d       = key_lat;
          tag_valid_d = 1'b1;
          owner_d     = grant_idx;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        rr_d    = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides the completion write of tag_valid.
    if (flush_i) begin
      tag_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant_idx <= '0;
      key_lat   <= '0;
      tag       <= '0;
      tag_valid <= 1'b0;
      owner     <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_d;
      grant_idx <= grant_d;
      key_lat   <= key_lat_d;
      tag       <= tag_d;
      tag_valid <= tag_valid_d;
      owner     <= owner_d;
      rr_ptr    <= rr_d;
    end
  end

  always_comb begin
    req_done_o = '0;
    if (state == S_RESP) begin
      req_done_o[grant_idx] = 1'b1;
    end
  end

  assign ke_valid_o   = (state == S_LAUNCH);
  assign ke_key_o     = key_lat;
  assign keys_valid_o = tag_valid;
  assign keys_owner_o = owner;
  assign busy_o       = (state != S_IDLE);

endmodule

// File: doc/key_sched_arbiter.md
# key_sched_arbiter

Shares one `key_expansion` instance among `NUM_REQ` cipher requesters. It round-robin arbitrates key-load requests and keeps a one-entry tag of the key currently expanded in the round-key bank. On a tag hit it answers without re-expanding. On a miss it launches the expander, waits for completion, updates the tag, then answers. It sits between the cipher cores and the expander and owns the expander's `valid_i`/`key_i` handshake.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 1..8.
- `IDW`, default `$clog2(NUM_REQ)` with a minimum of 1: width of the owner index.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid_i` in `NUM_REQ`: per-requester key-load request.
- `req_key_i` in `NUM_REQ`×128: per-requester cipher key, unpacked array.
- `req_done_o` out `NUM_REQ`: one-cycle completion pulse to the granted requester.
- `flush_i` in 1: invalidate the cached tag.
- `ke_valid_o` out 1: drives expander `valid_i`.
- `ke_ready_i` in 1: from expander `ready_o`.
- `ke_key_o` out 128: drives expander `key_i`.
- `ke_done_i` in 1: from expander `valid_o`.
- `keys_valid_o` out 1: the expander bank holds the fully expanded tag key.
- `keys_owner_o` out `IDW`: index of the requester whose key is in the bank.
- `busy_o` out 1: the FSM is not in S_IDLE.

## Operation
- **Registers:**
  - `state`, `grant_idx`, `key_lat` (128 bits).
  - `tag` (128 bits), `tag_valid`, `owner`.
  - `rr_ptr` (`IDW` bits).
- **S_IDLE:**
  - Search `req_valid_i` starting at `rr_ptr` and wrapping modulo `NUM_REQ`.
  - The first set bit wins. Latch its index into `grant_idx` and its key into `key_lat`, then go to S_CHECK.
  - If no request is set, stay in S_IDLE.
- **S_CHECK:**
  - If `tag_valid` and `key_lat == tag`, this is a hit: set `owner = grant_idx` and go to S_RESP.
  - Otherwise go to S_LAUNCH.
- **S_LAUNCH:**
  - `ke_valid_o = 1` and `ke_key_o = key_lat`.
  - Clear `tag_valid` on entry, because the bank is about to be overwritten.
  - Go to S_WAIT on the cycle `ke_ready_i` is 1.
- **S_WAIT:**
  - On `ke_done_i = 1`, write `tag = key_lat`, `tag_valid = 1` and `owner = grant_idx`, then go to S_RESP.
  - `ke_done_i` is ignored in every other state.
- **S_RESP:**
  - `req_done_o[grant_idx] = 1` for exactly this cycle.
  - `rr_ptr = (grant_idx + 1) mod NUM_REQ`, then go to S_IDLE.
- **Outputs:**
  - `keys_valid_o = tag_valid`.
  - `keys_owner_o = owner`.
  - `ke_key_o = key_lat` in every state, so the value is stable under `ke_valid_o`.
- **Requester protocol:** hold `req_valid_i` and `req_key_i` stable until `req_done_o`. If `req_valid_i` is dropped early, the transaction still completes and still pulses `req_done_o`.
- **Flush:**
  - `flush_i` clears `tag_valid` at the next edge, in any state.
  - If flush coincides with the S_WAIT tag write, flush wins: `tag_valid = 0`, while `tag`, `owner` and `req_done_o` proceed as normal.
- **Request after own done:** a requester that re-requests right after its done pulse competes under round-robin in the next S_IDLE cycle.

## Timing
- **Reset values:**
  - State is S_IDLE; `rr_ptr = 0`.
  - `tag = 0`, `tag_valid = 0`, `owner = 0`, `key_lat = 0`, `grant_idx = 0`.
  - All outputs are 0.
- **Hit latency:** request sampled in S_IDLE at edge k → S_CHECK in cycle k+1 → `req_done_o` high in cycle k+2. Next arbitration can happen at k+3.
- **Miss latency:**
  - `ke_valid_o` is high from cycle k+2 until the handshake edge.
  - `req_done_o` goes high the cycle after `ke_done_i` is sampled.
  - With an idle expander, the total is 3 cycles plus the expander latency plus 1.
- **No overlap:** only one transaction is in flight; S_RESP never overlaps S_LAUNCH.
- **Reset mid-operation:**
  - Any state returns to S_IDLE and the tag is invalidated.
  - No `req_done_o` is issued for the aborted transaction.
  - The expander shares `rst_n`.
- **`NUM_REQ = 1`:** `rr_ptr` stays 0 and `keys_owner_o` stays 0.

## Test plan
- **Reset:** reset, then request 0 with key `000102…0f`. Expect a miss: `ke_valid_o` with that key, `req_done_o[0]` one cycle after `ke_done_i`, `keys_valid_o = 1`, `keys_owner_o = 0`.
- **Hit:** repeat the same key from requester 1. Expect a hit: `ke_valid_o` never rises, `req_done_o[1]` arrives 2 cycles after the request is sampled, `keys_owner_o = 1`.
- **Contention:** requesters 0 and 1 both request every cycle with distinct keys, from `rr_ptr = 0`. Grants must alternate 0, 1, 0, 1, each a miss, with `keys_valid_o = 0` from launch until done.
- **Flush:** assert `flush_i` while idle with a valid tag, then request the same key. Expect `keys_valid_o = 0` after one edge, and the request is a miss.
- **Flush on the done cycle:** assert `flush_i` in the same cycle as `ke_done_i`. Expect `req_done_o` to pulse and `keys_valid_o` to stay 0.
- **Reset during S_WAIT:** pull `rst_n` low mid-expansion. Expect outputs to go to 0 immediately, no done pulse, and the next request to be a miss granted from `rr_ptr = 0`.
